// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the writeback scheduler.
package regfile_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_IDX_W  = 4;
  localparam int REG_DATA_W = 16;
  localparam int SB_CNT_W   = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [SB_CNT_W-1:0]  sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Wrap-around priority search: grants the first request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [NUM_REQ-1:0] w_lo_mask;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_pick;

  // Requests below ptr are only considered when nothing at or above ptr is valid.
  assign w_lo_mask = (NUM_REQ'(1) << ptr) - NUM_REQ'(1);
  assign w_masked  = req & ~w_lo_mask;
  assign w_pick    = (|w_masked) ? w_masked : req;

  // Isolate the lowest set bit of the chosen vector.
  assign gnt = w_pick & (~w_pick + NUM_REQ'(1));

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among NUM_REQ writeback sources and tracks
// pending writes per register. Define WBSCHED_RR_EN for round-robin; default is fixed priority.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_dst,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       alloc_valid,
  input  logic [ADDR_W-1:0]          alloc_reg,
  output logic                       WriteReg,
  output logic [ADDR_W-1:0]          DstReg,
  output logic [DATA_W-1:0]          DstData,
  output logic [NUM_REGS-1:0]        busy,
  output logic                       sb_err
);

  // Handshake: a transfer happens on a rising edge when req_valid[i] and
  // req_ready[i] are both high; ready never waits on anything but valid.

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_ready;
  logic [PTR_W-1:0]   w_ptr;
  logic               w_hs;
  logic [ADDR_W-1:0]  w_sel_dst;
  logic [DATA_W-1:0]  w_sel_data;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req(req_valid),
    .ptr(w_ptr),
    .gnt(w_gnt)
  );

  assign w_ready   = w_gnt & {NUM_REQ{rst}};
  assign req_ready = w_ready;
  assign w_hs      = |w_ready;

`ifdef WBSCHED_RR_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_gidx;

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_gidx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_comb begin
    w_sel_dst  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_dst  = req_dst[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  logic              r_write;
  logic [ADDR_W-1:0] r_dst;
  logic [DATA_W-1:0] r_data;

  // R0 writes complete the handshake but never raise the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write <= 1'b0;
      r_dst   <= '0;
      r_data  <= '0;
    end else if (w_hs) begin
      r_write <= (w_sel_dst != '0);
      r_dst   <= w_sel_dst;
      r_data  <= w_sel_data;
    end else begin
      r_write <= 1'b0;
    end
  end

  assign WriteReg = r_write;
  assign DstReg   = r_dst;
  assign DstData  = r_data;

  sb_cnt_t r_cnt     [NUM_REGS];
  sb_cnt_t w_cnt_nxt [NUM_REGS];
  logic    w_err_set;
  logic    w_inc;
  logic    w_dec;
  logic    r_err;

  // Allocation and retirement on the same register cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    w_inc     = 1'b0;
    w_dec     = 1'b0;
    w_cnt_nxt[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_inc = alloc_valid && (alloc_reg == ADDR_W'(r));
      w_dec = r_write && (r_dst == ADDR_W'(r));
      if (w_inc && !w_dec) begin
        if (r_cnt[r] == SB_CNT_MAX) w_err_set = 1'b1;
        else                        w_cnt_nxt[r] = r_cnt[r] + sb_cnt_t'(1);
      end else if (w_dec && !w_inc) begin
        if (r_cnt[r] == '0) w_err_set = 1'b1;
        else                w_cnt_nxt[r] = r_cnt[r] - sb_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_err_set;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = (r_cnt[r] != '0);
    end
  end

  assign sb_err = r_err;

endmodule
